serv_sleep_ctrl: RTL and testbench
==================================

# serv_sleep_ctrl

Parametrised sleep/wake controller for the SERV core. It is the successor to the single-source sleep logic. It accepts a WFI-style sleep request at the end of a serial instruction and asserts a registered clock-halt for the core clock gate. It wakes on any of `IRQ_W` individually enabled interrupt lines, after a programmable clock-restart delay, and reports which sources caused the wake. The block runs entirely on the free-running clock, and all outputs are glitch-free registers.

## Interface
Parameters:
- `IRQ_W`, default 2: number of interrupt/wake sources, ≥1.
- `WAKE_DELAY`, default 2: extra cycles that halt is held after a wake event, ≥0.
- `RESET_STRATEGY`, default "MINI": if "NONE", datapath register `o_wake_src` is not reset. Control state is always reset.

Ports:
- `i_clk`, in, 1: free-running clock. Never gated by this block.
- `i_rst`, in, 1: reset. Reset is synchronous and active-high.
- `i_irq`, in, `IRQ_W`: level-sensitive interrupt lines.
- `i_irq_en`, in, `IRQ_W`: per-line wake enable mask.
- `i_sleep_request`, in, 1: WFI decoded.
- `i_cnt_done`, in, 1: last cycle of the current serial instruction.
- `o_clk_halt`, out, 1: gate the core clock when high.
- `o_sleeping`, out, 1: high only in state SLEEP.
- `o_wake`, out, 1: one-cycle pulse when halt deasserts after a sleep.
- `o_wake_src`, out, `IRQ_W`: enabled sources captured at the wake event. Held until the next capture.

## Operation
- Definition: `wake_hit = |(i_irq & i_irq_en)`.
- States are RUN, SLEEP and WAKE. The down-counter `cnt` is `max(1,$clog2(WAKE_DELAY+1))` bits wide.
- RUN:
  - If `i_sleep_request & i_cnt_done & !wake_hit`, go to SLEEP.
  - If `i_sleep_request & i_cnt_done & wake_hit`, stay in RUN. The WFI completes as a NOP: no halt, no `o_wake`, `o_wake_src` unchanged.
  - A request without `i_cnt_done` is ignored.
- SLEEP:
  - If `wake_hit`, capture `o_wake_src <= i_irq & i_irq_en`.
  - If `WAKE_DELAY==0`, go to RUN.
  - Otherwise go to WAKE with `cnt <= WAKE_DELAY`.
- WAKE:
  - Decrement `cnt` each cycle.
  - When `cnt==1`, go to RUN.
  - IRQ deassertion or change during WAKE has no effect; the wake is committed.
- Registered outputs:
  - `o_clk_halt` = (next state != RUN).
  - `o_sleeping` = (next state == SLEEP).
  - `o_wake` = 1 for exactly the cycle whose state is RUN and whose previous state was SLEEP or WAKE.
- `i_sleep_request` is ignored in SLEEP and WAKE.
- Masked lines (`i_irq_en=0`) never wake the core and never appear in `o_wake_src`.
- Reset has priority over every other event, including reset mid-SLEEP or mid-WAKE.
  - State goes to RUN and `cnt` to 0.
  - `o_clk_halt`, `o_sleeping` and `o_wake` go to 0 on the first cycle after `i_rst` is sampled high.
  - `o_wake_src` goes to 0 unless `RESET_STRATEGY=="NONE"`.

## Timing
- Sleep entry: request with `cnt_done` sampled at edge N gives `o_clk_halt=1` and `o_sleeping=1` after edge N. Latency is 1 cycle.
- Wake: `wake_hit` sampled at edge M (in SLEEP) gives the following.
  - `o_sleeping=0` after edge M.
  - `o_clk_halt=0` and `o_wake=1` after edge M+`WAKE_DELAY`. Total latency is `WAKE_DELAY+1` edges from the IRQ sample.
  - `o_wake_src` is valid after edge M and stable through the `o_wake` pulse.
- `o_wake` lasts exactly one cycle and deasserts at edge M+`WAKE_DELAY`+1.
- Back-to-back WFI:
  - A new request may be accepted in the same cycle that `o_wake=1`, if `i_cnt_done` is high.
  - Minimum halt-low gap is 1 cycle.
- All outputs change only on the rising edge of `i_clk`. There are no combinational input-to-output paths.

## Test plan
- **Reset mid-sleep.** `IRQ_W=2`, `WAKE_DELAY=2`. Enter SLEEP, then assert `i_rst` for 1 cycle → the next cycle has `o_clk_halt=0`, `o_sleeping=0`, `o_wake=0`, `o_wake_src=2'b00`.
- **Basic wake.** Request + `cnt_done` at cycle 5 → halt=1 from cycle 6. Then `i_irq=2'b10`, `i_irq_en=2'b11` at cycle 10 → `o_sleeping=0` at cycle 11, `o_wake_src=2'b10` at 11, halt=0 and `o_wake=1` at cycle 13, `o_wake=0` at 14.
- **Masked source.** In SLEEP with `i_irq=2'b01` and `i_irq_en=2'b10` for 20 cycles → halt stays 1 and `o_wake` stays 0. Then set `i_irq_en=2'b11` → wake with `o_wake_src=2'b01`.
- **WFI as NOP and ignored request.** Request + `cnt_done` with an enabled IRQ already high → halt never asserts, `o_wake` stays 0. Request without `cnt_done` → no state change.
- **Zero delay and IRQ glitch.** With `WAKE_DELAY=0`, an IRQ at cycle M gives halt=0 and `o_wake=1` at M+1. With `WAKE_DELAY=3`, an IRQ pulsed for 1 cycle still produces halt=0 exactly 4 cycles later.
- **Back-to-back WFI.** A new request + `cnt_done` in the `o_wake` cycle → halt low for exactly 1 cycle, then SLEEP again.

Source files
------------

// File: rtl/serv_sleep_ctrl.sv
// Sleep/wake controller for the SERV core: halts the core clock on WFI and
// releases it a programmable number of cycles after any enabled interrupt.
module serv_sleep_ctrl #(
  parameter int IRQ_W          = 2,
  parameter int WAKE_DELAY     = 2,
  parameter     RESET_STRATEGY = "MINI"
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [IRQ_W-1:0] i_irq,
  input  logic [IRQ_W-1:0] i_irq_en,
  input  logic             i_sleep_request,
  input  logic             i_cnt_done,
  output logic             o_clk_halt,
  output logic             o_sleeping,
  output logic             o_wake,
  output logic [IRQ_W-1:0] o_wake_src
);

  localparam int CNT_W = (WAKE_DELAY > 0) ? $clog2(WAKE_DELAY + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAKE_DELAY);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_SLEEP = 2'd1;
  localparam logic [1:0] ST_WAKE  = 2'd2;

  // The source capture register is the only datapath state; it may skip reset.
  localparam bit RESET_SRC = (RESET_STRATEGY != "NONE");

  logic [1:0]       state_r;
  logic [1:0]       state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic [IRQ_W-1:0] hit_vec_s;
  logic             wake_hit_s;
  logic             capture_s;

  // Enabled interrupt lines and their reduction.
  always_comb begin
    hit_vec_s  = i_irq & i_irq_en;
    wake_hit_s = |hit_vec_s;
  end

  // Next-state, delay counter and source-capture decode.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    capture_s = 1'b0;
    case (state_r)
      ST_RUN: begin
        // A WFI that finds an enabled IRQ already pending retires as a NOP.
        if (i_sleep_request && i_cnt_done && !wake_hit_s) begin
          state_s = ST_SLEEP;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_SLEEP: begin
        if (wake_hit_s) begin
          capture_s = 1'b1;
          if (WAKE_DELAY == 0) begin
            state_s = ST_RUN;
          end else begin
            state_s = ST_WAKE;
            cnt_s   = CNT_LOAD;
          end
        end else begin
          state_s = ST_SLEEP;
        end
      end
      ST_WAKE: begin
        // Committed wake: IRQ lines are no longer consulted here.
        if (cnt_r <= CNT_ONE) begin
          state_s = ST_RUN;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = ST_WAKE;
          cnt_s   = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_s = ST_RUN;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // Control state and registered outputs, all derived from the next state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r    <= ST_RUN;
      cnt_r      <= CNT_ZERO;
      o_clk_halt <= 1'b0;
      o_sleeping <= 1'b0;
      o_wake     <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      o_clk_halt <= (state_s != ST_RUN);
      o_sleeping <= (state_s == ST_SLEEP);
      o_wake     <= (state_s == ST_RUN) && (state_r != ST_RUN);
    end
  end

  // Wake-source capture; held until the next wake event.
  always_ff @(posedge i_clk) begin
    if (i_rst && RESET_SRC) begin
      o_wake_src <= {IRQ_W{1'b0}};
    end else if (capture_s && !i_rst) begin
      o_wake_src <= hit_vec_s;
    end else begin
      o_wake_src <= o_wake_src;
    end
  end

endmodule

// File: tb/tb_serv_sleep_ctrl.sv
// Scoreboard bench for serv_sleep_ctrl: three instances (WAKE_DELAY 2, 0, 3)
// driven by directed vectors; a negedge monitor checks queued expectations.
module tb_serv_sleep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst      [3];
  logic [1:0] irq      [3];
  logic [1:0] irq_en   [3];
  logic       req      [3];
  logic       done     [3];
  logic       halt     [3];
  logic       sleeping [3];
  logic       wake     [3];
  logic [1:0] wsrc     [3];

  serv_sleep_ctrl #(.IRQ_W(2), .WAKE_DELAY(2)) dut_d2 (
    .i_clk(clk), .i_rst(rst[0]), .i_irq(irq[0]), .i_irq_en(irq_en[0]),
    .i_sleep_request(req[0]), .i_cnt_done(done[0]), .o_clk_halt(halt[0]),
    .o_sleeping(sleeping[0]), .o_wake(wake[0]), .o_wake_src(wsrc[0]));

  serv_sleep_ctrl #(.IRQ_W(2), .WAKE_DELAY(0)) dut_d0 (
    .i_clk(clk), .i_rst(rst[1]), .i_irq(irq[1]), .i_irq_en(irq_en[1]),
    .i_sleep_request(req[1]), .i_cnt_done(done[1]), .o_clk_halt(halt[1]),
    .o_sleeping(sleeping[1]), .o_wake(wake[1]), .o_wake_src(wsrc[1]));

  serv_sleep_ctrl #(.IRQ_W(2), .WAKE_DELAY(3)) dut_d3 (
    .i_clk(clk), .i_rst(rst[2]), .i_irq(irq[2]), .i_irq_en(irq_en[2]),
    .i_sleep_request(req[2]), .i_cnt_done(done[2]), .o_clk_halt(halt[2]),
    .o_sleeping(sleeping[2]), .o_wake(wake[2]), .o_wake_src(wsrc[2]));

  typedef struct {
    int         dut;
    int         cyc;
    logic       halt;
    logic       sl;
    logic       wk;
    logic [1:0] src;
    bit         chk_src;
    string      name;
  } exp_t;

  typedef struct {
    int         dut;
    int         cyc;
    logic [1:0] src;
  } wk_t;

  exp_t exp_q[$];
  wk_t  wk_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  bit end_req = 1'b0;
  bit end_done = 1'b0;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_st(input int d, input int at, input logic h, input logic s,
                           input logic w, input logic [1:0] src, input bit cs,
                           input string nm);
    exp_t e;
    e.dut = d; e.cyc = at; e.halt = h; e.sl = s; e.wk = w;
    e.src = src; e.chk_src = cs; e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic expect_wake(input int d, input int at, input logic [1:0] src);
    wk_t w;
    w.dut = d; w.cyc = at; w.src = src;
    wk_q.push_back(w);
  endtask

  task automatic enter_sleep(input int d, input string nm);
    req[d] = 1'b1; done[d] = 1'b1;
    expect_st(d, cyc + 1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, nm);
    step(1);
    req[d] = 1'b0; done[d] = 1'b0;
  endtask

  // Monitor: checks wake pulses against the wake queue and due state expectations.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (wake[d] === 1'b1) begin
        int idx;
        idx = -1;
        foreach (wk_q[i]) if (idx < 0 && wk_q[i].dut == d) idx = i;
        n_tests++;
        if (idx < 0) begin
          n_fail++;
          $display("FAIL unexpected_wake dut%0d cyc%0d: got o_wake=1, required 0", d, cyc);
        end else begin
          if (wk_q[idx].cyc != cyc || wk_q[idx].src !== wsrc[d]) begin
            n_fail++;
            $display("FAIL wake_event dut%0d: got cyc%0d src=%b, required cyc%0d src=%b",
                     d, cyc, wsrc[d], wk_q[idx].cyc, wk_q[idx].src);
          end
          wk_q.delete(idx);
        end
      end
    end
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc <= cyc) begin
        exp_t e;
        int   d;
        e = exp_q[i];
        d = e.dut;
        n_tests++;
        if (e.cyc != cyc) begin
          n_fail++;
          $display("FAIL %s dut%0d: expectation for cyc%0d expired at cyc%0d", e.name, d, e.cyc, cyc);
        end else if (halt[d] !== e.halt || sleeping[d] !== e.sl || wake[d] !== e.wk ||
                     (e.chk_src && wsrc[d] !== e.src)) begin
          n_fail++;
          $display("FAIL %s dut%0d cyc%0d: got halt=%b sleeping=%b wake=%b src=%b, required halt=%b sleeping=%b wake=%b src=%b%s",
                   e.name, d, cyc, halt[d], sleeping[d], wake[d], wsrc[d],
                   e.halt, e.sl, e.wk, e.src, e.chk_src ? "" : "(unchecked)");
        end
        exp_q.delete(i);
      end
    end
    if (end_req && !end_done) begin
      n_tests++;
      if (wk_q.size() != 0) begin
        n_fail++;
        $display("FAIL missing_wake: got %0d pending wake events, required 0 (first dut%0d cyc%0d)",
                 wk_q.size(), wk_q[0].dut, wk_q[0].cyc);
      end
      n_tests++;
      if (exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL unchecked_expect: got %0d pending expectations, required 0", exp_q.size());
      end
      end_done = 1'b1;
    end
  end

  int t;

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; irq[d] = 2'b00; irq_en[d] = 2'b00; req[d] = 1'b0; done[d] = 1'b0;
      expect_st(d, 1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, "reset_state");
    end
    step(2);
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;
    step(2);

    // Basic wake, WAKE_DELAY=2
    enter_sleep(0, "basic_sleep_entry");
    step(3);
    t = cyc;
    irq[0] = 2'b10; irq_en[0] = 2'b11;
    expect_st(0, t + 1, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, "basic_wake_m1");
    expect_st(0, t + 2, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, "basic_wake_m2");
    expect_st(0, t + 3, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, "basic_wake_pulse");
    expect_st(0, t + 4, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, "basic_wake_after");
    expect_wake(0, t + 3, 2'b10);
    step(1);
    irq[0] = 2'b00;
    step(4);

    // Masked source never wakes
    enter_sleep(0, "masked_sleep_entry");
    irq[0] = 2'b01; irq_en[0] = 2'b10;
    t = cyc;
    expect_st(0, t + 10, 1'b1, 1'b1, 1'b0, 2'b10, 1'b1, "masked_hold_10");
    expect_st(0, t + 20, 1'b1, 1'b1, 1'b0, 2'b10, 1'b1, "masked_hold_20");
    step(20);
    t = cyc;
    irq_en[0] = 2'b11;
    expect_st(0, t + 1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, "masked_unmask_m1");
    expect_st(0, t + 3, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, "masked_unmask_pulse");
    expect_wake(0, t + 3, 2'b01);
    step(4);

    // WFI as NOP with enabled IRQ pending, then request without cnt_done
    irq[0] = 2'b10; irq_en[0] = 2'b10;
    req[0] = 1'b1; done[0] = 1'b1;
    t = cyc;
    expect_st(0, t + 1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, "wfi_nop_1");
    expect_st(0, t + 2, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, "wfi_nop_2");
    step(2);
    req[0] = 1'b0; done[0] = 1'b0; irq[0] = 2'b00;
    step(1);
    req[0] = 1'b1; done[0] = 1'b0;
    t = cyc;
    expect_st(0, t + 3, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, "req_no_done");
    step(3);
    req[0] = 1'b0;
    step(1);

    // Reset mid-sleep
    enter_sleep(0, "rst_sleep_entry");
    step(2);
    rst[0] = 1'b1;
    t = cyc;
    expect_st(0, t + 1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, "reset_mid_sleep");
    step(1);
    rst[0] = 1'b0;
    irq[0] = 2'b01; irq_en[0] = 2'b11;
    t = cyc;
    expect_st(0, t + 3, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, "post_reset_run");
    step(3);
    irq[0] = 2'b00;
    step(1);

    // Back-to-back WFI in the wake cycle
    enter_sleep(0, "b2b_sleep_entry");
    step(1);
    t = cyc;
    irq[0] = 2'b01; irq_en[0] = 2'b11;
    expect_wake(0, t + 3, 2'b01);
    expect_st(0, t + 3, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, "b2b_wake_pulse");
    step(1);
    irq[0] = 2'b00;
    step(2);
    req[0] = 1'b1; done[0] = 1'b1;
    expect_st(0, t + 4, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, "b2b_resleep");
    step(1);
    req[0] = 1'b0; done[0] = 1'b0;
    step(2);
    t = cyc;
    irq[0] = 2'b10;
    expect_wake(0, t + 3, 2'b10);
    expect_st(0, t + 1, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, "b2b_second_wake");
    step(1);
    irq[0] = 2'b00;
    step(4);

    // Zero delay
    enter_sleep(1, "d0_sleep_entry");
    step(2);
    t = cyc;
    irq[1] = 2'b10; irq_en[1] = 2'b11;
    expect_st(1, t + 1, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, "d0_wake_pulse");
    expect_st(1, t + 2, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, "d0_after");
    expect_wake(1, t + 1, 2'b10);
    step(1);
    irq[1] = 2'b00;
    step(3);

    // Delay 3 with a one-cycle IRQ glitch
    enter_sleep(2, "d3_sleep_entry");
    step(2);
    t = cyc;
    irq[2] = 2'b01; irq_en[2] = 2'b01;
    expect_st(2, t + 1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, "d3_glitch_m1");
    expect_st(2, t + 3, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, "d3_glitch_m3");
    expect_st(2, t + 4, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, "d3_glitch_pulse");
    expect_st(2, t + 5, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, "d3_glitch_after");
    expect_wake(2, t + 4, 2'b01);
    step(1);
    irq[2] = 2'b00;
    step(6);

    end_req = 1'b1;
    step(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
